// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit (instr_fetch).
// Consumers import ifetch_pkg::*.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  localparam logic [1:0] RVC_OPC_MASK  = 2'b11;
  localparam logic [2:0] INSTR_SIZE_16 = 3'd2;
  localparam logic [2:0] INSTR_SIZE_32 = 3'd4;

  // A halfword whose low opcode bits are both set opens a 32-bit instruction.
  function automatic logic is_wide(input logic [15:0] hw);
    return (hw[1:0] & RVC_OPC_MASK) == RVC_OPC_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle of the fetch stage: redirect input, memory read channel and
// instruction handshake. master = fetch unit, slave = core/memory side.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);

  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_data;
  logic [2:0]        instr_size;
  logic [31:0]       instr_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  instr_ready,
    output mem_req_valid, mem_req_addr,
    output instr_valid, instr_data, instr_size, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output instr_ready,
    input  mem_req_valid, mem_req_addr,
    input  instr_valid, instr_data, instr_size, instr_pc
  );

endinterface

// File: rtl/ifetch_hbuf.sv
// Halfword shift buffer of the fetch stage. With IFETCH_RVC_EN it holds four
// halfword slots (slot 0 oldest); without it, a single 32-bit word.
module ifetch_hbuf
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        skip_low,
  input  logic        rd_en,
  input  logic        rd_two,
  output logic [15:0] slot0,
  output logic [15:0] slot1,
  output logic [2:0]  count
);

`ifdef IFETCH_RVC_EN

  logic [3:0][15:0] slots_q, slots_n, shifted;
  logic [2:0]       count_q, count_n, count_s;

  // Consumption shifts first so an append in the same cycle lands behind the
  // surviving slots.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    shifted = slots_q;
    count_s = count_q;
    if (rd_en) begin
      if (rd_two) begin
        shifted = {32'h0, slots_q[3:2]};
        count_s = count_q - 3'd2;
      end else begin
        shifted = {16'h0, slots_q[3:1]};
        count_s = count_q - 3'd1;
      end
    end

    slots_n = shifted;
    count_n = count_s;
    if (wr_en) begin
      if (skip_low) begin
        slots_n[count_s[1:0]] = wr_data[31:16];
        count_n               = count_s + 3'd1;
      end else begin
        slots_n[count_s[1:0]]        = wr_data[15:0];
        slots_n[count_s[1:0] + 2'd1] = wr_data[31:16];
        count_n                      = count_s + 3'd2;
      end
    end
    if (flush) count_n = 3'd0;
  end

  // NOTE: the slot storage is reset along with the count so the data path is never X out of reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slots_q <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state updates use <= so every flop samples values from before the edge.
      slots_q <= slots_n;
      count_q <= count_n;
    end
  end

  assign slot0 = slots_q[0];
  assign slot1 = slots_q[1];
  assign count = count_q;

`else

  logic [31:0] word_q;
  logic        full_q;
  logic        unused_ok;

  // Only whole words move through here; the halfword controls have no role.
  assign unused_ok = skip_low ^ rd_two;

  // The fetch FSM only requests while the word is empty, so append and
  // consume never coincide.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      word_q <= '0;
      full_q <= 1'b0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (wr_en) begin
      word_q <= wr_data;
      full_q <= 1'b1;
    end else if (rd_en) begin
      full_q <= 1'b0;
    end
  end

  assign slot0 = word_q[15:0];
  assign slot1 = word_q[31:16];
  assign count = full_q ? 3'd2 : 3'd0;

`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: word-aligned memory reads, instruction assembly and a
// valid/ready instruction port. IFETCH_RVC_EN enables 16-bit (RVC) support.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic          clk,
  input  logic          nreset,
  instr_fetch_if.master bus
);

`ifdef IFETCH_RVC_EN
  localparam logic [2:0]  REQ_LIMIT = 3'd2;
  localparam logic [31:0] PC_MASK   = 32'hFFFF_FFFE;
`else
  // Only an empty word buffer has room for a whole returned word.
  localparam logic [2:0]  REQ_LIMIT = 3'd0;
  localparam logic [31:0] PC_MASK   = 32'hFFFF_FFFC;
`endif
  localparam logic [31:0] RESET_PC_M = RESET_PC & PC_MASK;

  fetch_state_e      state_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [31:0]       instr_pc_q;
  logic              drop_q;
  logic              skip_low;

  logic [15:0]       slot0, slot1;
  logic [2:0]        count;
  logic              wide, valid, fire, rsp_take, rsp_pending;
  logic [2:0]        size;
  logic [31:0]       redir_pc;
  logic [ADDR_W-1:0] fetch_word, redir_word;

  assign redir_pc   = bus.redirect_pc & PC_MASK;
  assign fetch_word = {fetch_pc_q[ADDR_W-1:2], 2'b00};
  assign redir_word = {redir_pc[ADDR_W-1:2], 2'b00};

`ifdef IFETCH_RVC_EN
  logic skip_q;

  // A fetch starting on an odd halfword drops the low half of its first word.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                 skip_q <= RESET_PC[1];
    else if (bus.redirect_valid) skip_q <= bus.redirect_pc[1];
    else if (rsp_take)           skip_q <= 1'b0;
  end

  assign skip_low = skip_q;
  assign wide     = is_wide(slot0);
  assign valid    = (count >= 3'd2) || (count == 3'd1 && !wide);
`else
  assign skip_low = 1'b0;
  assign wide     = 1'b1;
  assign valid    = (count == 3'd2);
`endif

  assign size = wide ? INSTR_SIZE_32 : INSTR_SIZE_16;

  // A redirect wins over both a same-cycle handshake and a same-cycle response.
  assign fire     = valid && bus.instr_ready && !bus.redirect_valid;
  assign rsp_take = (state_q == WAIT) && bus.mem_rsp_valid && !drop_q && !bus.redirect_valid;

  // An accepted request whose response has not yet arrived.
  assign rsp_pending = ((state_q == WAIT) && !bus.mem_rsp_valid) ||
                       ((state_q == REQ) && bus.mem_req_ready);

  ifetch_hbuf u_hbuf (
    .clk      (clk),
    .nreset   (nreset),
    .flush    (bus.redirect_valid),
    .wr_en    (rsp_take),
    .wr_data  (bus.mem_rsp_data),
    .skip_low (skip_low),
    .rd_en    (fire),
    .rd_two   (wide),
    .slot0    (slot0),
    .slot1    (slot1),
    .count    (count)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      fetch_pc_q  <= RESET_PC_M[ADDR_W-1:0];
      instr_pc_q  <= RESET_PC_M;
      drop_q      <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc_q <= redir_pc[ADDR_W-1:0];
      instr_pc_q <= redir_pc;
      if (rsp_pending) begin
        // Absorb the stale response before requesting the new target.
        drop_q      <= 1'b1;
        state_q     <= WAIT;
        req_valid_q <= 1'b0;
      end else begin
        drop_q      <= 1'b0;
        state_q     <= REQ;
        req_valid_q <= 1'b1;
        req_addr_q  <= redir_word;
      end
    end else begin
      if (fire) instr_pc_q <= instr_pc_q + 32'(size);
      case (state_q)
        IDLE: begin
          if (count <= REQ_LIMIT) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= fetch_word;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (drop_q) begin
              drop_q      <= 1'b0;
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= fetch_word;
            end else begin
              fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.instr_valid   = valid;
  assign bus.instr_size    = size;
  assign bus.instr_pc      = instr_pc_q;
  assign bus.instr_data    = !valid ? 32'h0 : (wide ? {slot1, slot0} : {16'h0, slot0});

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; the bench plays core and instruction memory.
// Covers both the RVC build (IFETCH_RVC_EN) and the 32-bit-only build.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic nreset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req_valid) break;
      tick();
    end
    check({tag, ".req_seen"}, 32'(bus.mem_req_valid), 32'h1);
  endtask

  // Accept one request at the expected address and answer the next cycle.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    wait_req(tag);
    check({tag, ".req_addr"}, bus.mem_req_addr, addr);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
  endtask

  task automatic take(input string tag, input logic [31:0] data, input logic [2:0] size,
                      input logic [31:0] pc);
    check({tag, ".valid"}, 32'(bus.instr_valid), 32'h1);
    check({tag, ".data"}, bus.instr_data, data);
    check({tag, ".size"}, 32'(bus.instr_size), 32'(size));
    check({tag, ".pc"}, bus.instr_pc, pc);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  // Accept the pending request, then hold the response back.
  task automatic accept_only(input string tag, input logic [31:0] addr);
    wait_req(tag);
    check({tag, ".req_addr"}, bus.mem_req_addr, addr);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    bus.instr_ready    = 1'b0;
    repeat (2) @(negedge clk);

    check("rst.req_valid", 32'(bus.mem_req_valid), 32'h0);
    check("rst.req_addr", bus.mem_req_addr, 32'h0);
    check("rst.instr_valid", 32'(bus.instr_valid), 32'h0);
    check("rst.instr_pc", bus.instr_pc, 32'h0);

    // First word with memory always ready: instr_valid three cycles after release.
    nreset            = 1'b1;
    bus.mem_req_ready = 1'b1;
    check("lat.c0_req", 32'(bus.mem_req_valid), 32'h0);
    tick();
    check("lat.c1_req", 32'(bus.mem_req_valid), 32'h1);
    check("lat.c1_addr", bus.mem_req_addr, 32'h0);
    tick();
    bus.mem_req_ready = 1'b0;
    check("lat.c2_req", 32'(bus.mem_req_valid), 32'h0);
    check("lat.c2_valid", 32'(bus.instr_valid), 32'h0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h00A0_0093;
    tick();
    bus.mem_rsp_valid = 1'b0;
    take("t1a", 32'h00A0_0093, 3'd4, 32'h0);
    serve("t1b", 32'h4, 32'h0011_0113);
    take("t1b", 32'h0011_0113, 3'd4, 32'h4);

`ifdef IFETCH_RVC_EN
    // Two compressed instructions in one word.
    redirect(32'h0);
    check("t2.flush", 32'(bus.instr_valid), 32'h0);
    serve("t2", 32'h0, 32'h4501_4505);
    take("t2a", 32'h0000_4505, 3'd2, 32'h0);
    take("t2b", 32'h0000_4501, 3'd2, 32'h2);

    // Compressed, then a 32-bit instruction straddling the word boundary.
    redirect(32'h0);
    serve("t3w0", 32'h0, 32'h0093_4501);
    take("t3a", 32'h0000_4501, 3'd2, 32'h0);
    check("t3.half_only", 32'(bus.instr_valid), 32'h0);
    serve("t3w1", 32'h4, 32'h0002_00A0);
    take("t3b", 32'h00A0_0093, 3'd4, 32'h2);
    check("t3.tail_data", bus.instr_data, 32'h0000_0002);

    // Redirect to an odd halfword while a response is outstanding.
    accept_only("t4", 32'h8);
    redirect(32'h102);
    check("t4.flush", 32'(bus.instr_valid), 32'h0);
    check("t4.req_hold", 32'(bus.mem_req_valid), 32'h0);
    check("t4.pc", bus.instr_pc, 32'h102);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("t4.stale_dropped", 32'(bus.instr_valid), 32'h0);
    check("t4.new_req", 32'(bus.mem_req_valid), 32'h1);
    check("t4.new_addr", bus.mem_req_addr, 32'h100);
    serve("t4", 32'h100, 32'h4501_ABCD);
    take("t4", 32'h0000_4501, 3'd2, 32'h102);

    // Fill all four slots, then stall the core.
    serve("t5w0", 32'h104, 32'h00A0_0093);
    serve("t5w1", 32'h108, 32'h4505_4501);
    for (int i = 0; i < 5; i++) begin
      check("t5.no_req", 32'(bus.mem_req_valid), 32'h0);
      check("t5.stable", bus.instr_data, 32'h00A0_0093);
      tick();
    end
    take("t5a", 32'h00A0_0093, 3'd4, 32'h104);
    take("t5b", 32'h0000_4501, 3'd2, 32'h108);

    // Reset while waiting on memory with an instruction still presented.
    accept_only("t6", 32'h10C);
    check("t6.pre_data", bus.instr_data, 32'h0000_4505);
    check("t6.pre_pc", bus.instr_pc, 32'h10A);
`else
    // Redirect while a response is outstanding; low PC bits are ignored.
    accept_only("t4", 32'h8);
    redirect(32'h102);
    check("t4.req_hold", 32'(bus.mem_req_valid), 32'h0);
    check("t4.pc", bus.instr_pc, 32'h100);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("t4.stale_dropped", 32'(bus.instr_valid), 32'h0);
    check("t4.new_req", 32'(bus.mem_req_valid), 32'h1);
    check("t4.new_addr", bus.mem_req_addr, 32'h100);
    serve("t4", 32'h100, 32'h0011_0113);
    take("t4", 32'h0011_0113, 3'd4, 32'h100);

    // Full word buffer with the core stalled.
    serve("t5", 32'h104, 32'h00A0_0093);
    for (int i = 0; i < 5; i++) begin
      check("t5.no_req", 32'(bus.mem_req_valid), 32'h0);
      check("t5.stable", bus.instr_data, 32'h00A0_0093);
      tick();
    end
    take("t5", 32'h00A0_0093, 3'd4, 32'h104);

    accept_only("t6", 32'h108);
`endif

    #1 nreset = 1'b0;
    #1;
    check("t6.req_valid", 32'(bus.mem_req_valid), 32'h0);
    check("t6.req_addr", bus.mem_req_addr, 32'h0);
    check("t6.instr_valid", 32'(bus.instr_valid), 32'h0);
    check("t6.instr_data", bus.instr_data, 32'h0);
    check("t6.instr_pc", bus.instr_pc, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    wait_req("t6.restart");
    check("t6.restart_addr", bus.mem_req_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
